// File: rtl/store_align_queue.sv
// Store align queue: lane-aligns M-stage stores (sb/sh/sw/swl/swr) into little-endian byte lanes with strobes, then buffers them for the data bus.
// Latency: an accepted store reaches bus_valid one cycle after acceptance when the queue is empty.
//          addr_err and chk_hit are combinational.
// Backpressure: req_ready is low while the registered count is full, even if the head drains that cycle.
//               The head is held stable while bus_ready is low.
// Ports: clk/reset (async, active-high); req_valid/req_type/req_addr/req_data/req_ready/addr_err (request side);
//        bus_valid/bus_ready/bus_addr/bus_data/bus_strb (drain side); chk_addr/chk_hit (load hazard); empty.
module store_align_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [4:0]    req_type,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_data,
    output logic          req_ready,
    output logic          addr_err,
    output logic          bus_valid,
    input  logic          bus_ready,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_data,
    output logic [3:0]    bus_strb,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_hit,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-3:0] waddr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [1:0]    w_off;
    logic          w_is_sb, w_is_sh, w_is_sw, w_is_swl, w_is_swr;
    logic          w_type_ok;
    logic          w_enq;
    logic          w_deq;
    entry_t        w_new;
    entry_t        w_head;
    logic [PW-1:0] w_rel;

    assign w_off    = req_addr[1:0];
    assign w_is_sb  = req_type[4];
    assign w_is_sh  = req_type[3];
    assign w_is_sw  = req_type[2];
    assign w_is_swl = req_type[1];
    assign w_is_swr = req_type[0];

    // Exactly one type bit set; zero or multiple bits means no store at all.
    assign w_type_ok = (req_type != 5'b0) && ((req_type & (req_type - 5'd1)) == 5'b0);

    assign addr_err = req_valid & w_type_ok &
                      ((w_is_sh & w_off[0]) | (w_is_sw & (w_off != 2'b00)));

    assign req_ready = (r_count != CW'(DEPTH));
    assign bus_valid = (r_count != '0);
    assign empty     = (r_count == '0);

    assign w_enq = req_valid & req_ready & w_type_ok & ~addr_err;
    assign w_deq = bus_valid & bus_ready;

    // Lane alignment happens before storage so the bus side is a plain register read.
    always_comb begin
        w_new.waddr = req_addr[AW-1:2];
        w_new.data  = '0;
        w_new.strb  = '0;
        if (w_is_sb) begin
            w_new.strb = 4'b0001 << w_off;
            w_new.data = {4{req_data[7:0]}};
        end else if (w_is_sh) begin
            w_new.strb = 4'b0011 << w_off;
            w_new.data = {2{req_data[15:0]}};
        end else if (w_is_sw) begin
            w_new.strb = 4'b1111;
            w_new.data = req_data;
        end else if (w_is_swl) begin
            // swl writes the upper bytes of rt into lanes 0..o.
            w_new.strb = 4'b1111 >> (2'd3 - w_off);
            w_new.data = req_data >> {(2'd3 - w_off), 3'b000};
        end else if (w_is_swr) begin
            // swr writes the lower bytes of rt into lanes o..3.
            w_new.strb = 4'b1111 << w_off;
            w_new.data = req_data << {w_off, 3'b000};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: validity comes from the count alone.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= w_new;
        end
    end

    // Outputs are forced to zero when empty, so reset leaves the bus outputs at 0.
    assign w_head   = r_mem[r_head];
    assign bus_addr = bus_valid ? {w_head.waddr, 2'b00} : '0;
    assign bus_data = bus_valid ? w_head.data : '0;
    assign bus_strb = bus_valid ? w_head.strb : '0;

    // An entry is live if its distance from the head is below the count.
    // Only stored entries are compared, so a same-cycle enqueue never hits.
    always_comb begin
        chk_hit = 1'b0;
        w_rel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rel = PW'(i) - r_head;
            if (({1'b0, w_rel} < r_count) && (r_mem[i].waddr == chk_addr[AW-1:2])) begin
                chk_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_align_queue.sv
module tb_store_align_queue;

    localparam logic [4:0] T_SB  = 5'b10000;
    localparam logic [4:0] T_SH  = 5'b01000;
    localparam logic [4:0] T_SW  = 5'b00100;
    localparam logic [4:0] T_SWL = 5'b00010;
    localparam logic [4:0] T_SWR = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [4:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_ready;
    logic        addr_err;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic [3:0]  bus_strb;
    logic [31:0] chk_addr;
    logic        chk_hit;
    logic        empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_align_queue #(.DEPTH(2), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .addr_err  (addr_err),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_strb  (bus_strb),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .empty     (empty)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] t, input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_type  = t;
        req_addr  = a;
        req_data  = d;
    endtask

    initial begin
        reset     = 1'b1;
        bus_ready = 1'b0;
        chk_addr  = 32'h0;
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        check_eq("rst_bus_valid", bus_valid, 0);
        check_eq("rst_empty",     empty, 1);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_chk_hit",   chk_hit, 0);
        check_eq("rst_bus_data",  bus_data, 0);
        check_eq("rst_bus_strb",  bus_strb, 0);
        check_eq("rst_bus_addr",  bus_addr, 0);

        // Alignment sweep with bus_ready high; requests are pipelined back to back
        bus_ready = 1'b1;
        drive(1'b1, T_SB, 32'h1003, 32'h11223344);
        step();
        drive(1'b1, T_SWL, 32'h1001, 32'h11223344);
        check_eq("sb_valid", bus_valid, 1);
        check_eq("sb_addr",  bus_addr, 32'h1000);
        check_eq("sb_strb",  bus_strb, 4'b1000);
        check_eq("sb_data",  bus_data, 32'h44444444);
        step();
        drive(1'b1, T_SWR, 32'h1001, 32'h11223344);
        check_eq("swl_strb", bus_strb, 4'b0011);
        check_eq("swl_data", bus_data, 32'h00001122);
        step();
        drive(1'b1, T_SH, 32'h1002, 32'h0000BEEF);
        check_eq("swr_strb", bus_strb, 4'b1110);
        check_eq("swr_data", bus_data, 32'h22334400);
        check_eq("swr_addr", bus_addr, 32'h1000);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        check_eq("sh_strb", bus_strb, 4'b1100);
        check_eq("sh_data", bus_data, 32'hBEEFBEEF);
        step();
        check_eq("sweep_empty", empty, 1);

        // Alignment errors and invalid types
        drive(1'b1, T_SH, 32'h2001, 32'h12345678);
        #1 check_eq("sh_ades", addr_err, 1);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        check_eq("sh_ades_empty", empty, 1);
        drive(1'b1, T_SW, 32'h2002, 32'h12345678);
        #1 check_eq("sw_ades", addr_err, 1);
        drive(1'b1, 5'b11000, 32'h2001, 32'h12345678);
        #1 check_eq("badtype_ades", addr_err, 0);
        step();
        check_eq("badtype_empty", empty, 1);
        drive(1'b1, 5'b00000, 32'h2000, 32'h12345678);
        step();
        check_eq("zerotype_empty", empty, 1);
        drive(1'b1, T_SW, 32'h2000, 32'hCAFEF00D);
        #1 check_eq("sw_ok_ades", addr_err, 0);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        check_eq("sw_ok_valid", bus_valid, 1);
        check_eq("sw_ok_addr",  bus_addr, 32'h2000);
        check_eq("sw_ok_data",  bus_data, 32'hCAFEF00D);
        step();
        check_eq("sw_ok_drain", empty, 1);

        // Backpressure
        bus_ready = 1'b0;
        drive(1'b1, T_SW, 32'h4000, 32'hAAAA0001);
        step();
        drive(1'b1, T_SW, 32'h4004, 32'hBBBB0002);
        step();
        drive(1'b1, T_SW, 32'h4008, 32'hCCCC0003);
        check_eq("bp_full_ready", req_ready, 0);
        check_eq("bp_head_a",     bus_data, 32'hAAAA0001);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        check_eq("bp_hold_data", bus_data, 32'hAAAA0001);
        check_eq("bp_hold_addr", bus_addr, 32'h4000);
        check_eq("bp_hold_strb", bus_strb, 4'b1111);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check_eq("bp_ready_back", req_ready, 1);
        check_eq("bp_head_b",     bus_data, 32'hBBBB0002);
        check_eq("bp_head_b_addr", bus_addr, 32'h4004);

        // Full with simultaneous drain
        drive(1'b1, T_SW, 32'h4010, 32'hDDDD0004);
        step();
        drive(1'b1, T_SW, 32'h4020, 32'hEEEE0005);
        bus_ready = 1'b1;
        check_eq("fd_ready_low", req_ready, 0);
        step();
        bus_ready = 1'b0;
        check_eq("fd_head_d",   bus_data, 32'hDDDD0004);
        check_eq("fd_ready_up", req_ready, 1);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        check_eq("fd_e_taken", req_ready, 0);
        check_eq("fd_still_d", bus_data, 32'hDDDD0004);
        bus_ready = 1'b1;
        step();
        check_eq("fd_head_e", bus_data, 32'hEEEE0005);
        check_eq("fd_addr_e", bus_addr, 32'h4020);
        step();
        check_eq("fd_empty", empty, 1);
        check_eq("fd_no_c",  bus_valid, 0);

        // Hazard check
        bus_ready = 1'b0;
        drive(1'b1, T_SW, 32'h3004, 32'h12345678);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        chk_addr = 32'h3006;
        #1 check_eq("hz_hit", chk_hit, 1);
        chk_addr = 32'h3008;
        #1 check_eq("hz_miss", chk_hit, 0);
        chk_addr = 32'h5000;
        drive(1'b1, T_SW, 32'h5000, 32'h55555555);
        #1 check_eq("hz_same_cycle_enq", chk_hit, 0);
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        chk_addr = 32'h3006;
        bus_ready = 1'b1;
        #1 check_eq("hz_head_leaving", chk_hit, 1);
        step();
        bus_ready = 1'b0;
        check_eq("hz_after_drain", chk_hit, 0);
        check_eq("hz_empty",       empty, 1);

        // Reset mid-operation
        drive(1'b1, T_SW, 32'h6000, 32'h66660006);
        step();
        drive(1'b1, T_SW, 32'h6004, 32'h66660007);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        check_eq("mr_full", req_ready, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("mr_bus_valid", bus_valid, 0);
        check_eq("mr_empty",     empty, 1);
        check_eq("mr_req_ready", req_ready, 1);
        check_eq("mr_bus_data",  bus_data, 0);
        step();
        reset = 1'b0;
        chk_addr = 32'h6000;
        #1 check_eq("mr_no_hit", chk_hit, 0);
        drive(1'b1, T_SW, 32'h7000, 32'h77770007);
        step();
        drive(1'b0, 5'b0, 32'h0, 32'h0);
        check_eq("mr_new_valid", bus_valid, 1);
        check_eq("mr_new_addr",  bus_addr, 32'h7000);
        check_eq("mr_new_data",  bus_data, 32'h77770007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
